// File: rtl/tl_log_arbiter.sv
// tl_log_arbiter: timestamps TileLink beat fires per channel, queues each channel in its own FIFO,
// and serializes the queued records round-robin, one per cycle, to the log writer.
module tl_log_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 256
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [4:0]          ch_fire,
    input  logic [39:0]         ch_opcode,
    input  logic [39:0]         ch_param,
    input  logic [39:0]         ch_source,
    input  logic [39:0]         ch_sink,
    input  logic [319:0]        ch_address,
    input  logic [5*DATA_W-1:0] ch_data,
    output logic                wen,
    output logic [7:0]          channel,
    output logic [7:0]          opcode,
    output logic [7:0]          param,
    output logic [7:0]          source,
    output logic [7:0]          sink,
    output logic [63:0]         address,
    output logic [63:0]         data_0,
    output logic [63:0]         data_1,
    output logic [63:0]         data_2,
    output logic [63:0]         data_3,
    output logic [63:0]         stamp,
    output logic [31:0]         drop_count,
    output logic                overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [7:0]        opcode;
        logic [7:0]        param;
        logic [7:0]        source;
        logic [7:0]        sink;
        logic [63:0]       address;
        logic [DATA_W-1:0] data;
        logic [63:0]       stamp;
    } rec_t;

    logic [63:0] stamp_cnt;
    logic [2:0]  rr;
    logic [2:0]  grant;
    logic [2:0]  off;
    logic [3:0]  sum;
    logic        grant_valid;
    logic [4:0]  empty;
    logic [4:0]  full;
    logic [4:0]  pop;
    logic [4:0]  push;
    logic [4:0]  drop;
    logic [4:0]  rot;
    logic [32:0] drop_sum;
    rec_t        head [5];
    rec_t        hd;

    for (genvar c = 0; c < 5; c++) begin : g_fifo
        rec_t        mem [FIFO_DEPTH];
        rec_t        rec_in;
        logic [AW:0] wr_ptr;
        logic [AW:0] rd_ptr;
        assign rec_in  = {ch_opcode[8*c +: 8], ch_param[8*c +: 8], ch_source[8*c +: 8], ch_sink[8*c +: 8],
                          ch_address[64*c +: 64], ch_data[DATA_W*c +: DATA_W], stamp_cnt};
        assign empty[c] = wr_ptr == rd_ptr;
        assign full[c]  = (wr_ptr ^ rd_ptr) == (AW+1)'(FIFO_DEPTH);
        assign head[c]  = mem[rd_ptr[AW-1:0]];
        always_ff @(posedge clock) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push[c]) begin
                    mem[wr_ptr[AW-1:0]] <= rec_in;
                    wr_ptr              <= wr_ptr + (AW+1)'(1);
                end
                if (pop[c])
                    rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Rotate occupancy so bit 0 is channel rr, pick the lowest set bit, then rotate back.
    always_comb begin
        rot = 5'({2{~empty}} >> rr);
        off = 3'd0;
        for (int k = 4; k >= 0; k--)
            off = rot[k] ? 3'(k) : off;
        sum         = {1'b0, rr} + {1'b0, off};
        grant       = sum > 4'd4 ? 3'(sum - 4'd5) : sum[2:0];
        grant_valid = ~&empty;
    end

    assign pop      = grant_valid ? 5'b1 << grant : 5'b0;
    assign drop     = ch_fire & full & ~pop;
    assign push     = ch_fire & ~drop;
    assign hd       = head[grant];
    assign drop_sum = {1'b0, drop_count} + 33'($countones(drop));

    always_ff @(posedge clock) begin
        if (reset) begin
            stamp_cnt  <= '0;
            rr         <= '0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            stamp_cnt  <= stamp_cnt + 64'd1;
            drop_count <= drop_sum[32] ? '1 : drop_sum[31:0];
            overflow   <= overflow | (|drop);
            if (grant_valid)
                rr <= grant == 3'd4 ? 3'd0 : grant + 3'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wen     <= 1'b0;
            channel <= '0;
            opcode  <= '0;
            param   <= '0;
            source  <= '0;
            sink    <= '0;
            address <= '0;
            data_0  <= '0;
            data_1  <= '0;
            data_2  <= '0;
            data_3  <= '0;
            stamp   <= '0;
        end else begin
            wen <= grant_valid;
            if (grant_valid) begin
                channel <= {5'd0, grant};
                opcode  <= hd.opcode;
                param   <= hd.param;
                source  <= hd.source;
                sink    <= hd.sink;
                address <= hd.address;
                data_0  <= hd.data[63:0];
                data_1  <= hd.data[127:64];
                data_2  <= hd.data[191:128];
                data_3  <= hd.data[255:192];
                stamp   <= hd.stamp;
            end
        end
    end
endmodule

// File: tb/tb_tl_log_arbiter.sv
// tb_tl_log_arbiter: directed checks of capture, latency, round-robin order, drops and stamp handling.
module tb_tl_log_arbiter;
    logic          clock = 1'b0;
    logic          reset;
    logic [4:0]    ch_fire;
    logic [39:0]   ch_opcode;
    logic [39:0]   ch_param;
    logic [39:0]   ch_source;
    logic [39:0]   ch_sink;
    logic [319:0]  ch_address;
    logic [1279:0] ch_data;
    logic          wen;
    logic [7:0]    channel;
    logic [7:0]    opcode;
    logic [7:0]    param;
    logic [7:0]    source;
    logic [7:0]    sink;
    logic [63:0]   address;
    logic [63:0]   data_0;
    logic [63:0]   data_1;
    logic [63:0]   data_2;
    logic [63:0]   data_3;
    logic [63:0]   stamp;
    logic [31:0]   drop_count;
    logic          overflow;
    int            checks = 0;
    int            failures = 0;

    // Expected burst emission order, {channel, burst cycle of the fire}.
    logic [7:0] burst_seq [27] = '{8'h20, 8'h30, 8'h40, 8'h00, 8'h10, 8'h21, 8'h31, 8'h41, 8'h01,
                                   8'h11, 8'h22, 8'h32, 8'h42, 8'h02, 8'h12, 8'h23, 8'h33, 8'h43,
                                   8'h03, 8'h13, 8'h24, 8'h34, 8'h44, 8'h04, 8'h15, 8'h26, 8'h37};

    tl_log_arbiter #(.FIFO_DEPTH(4), .DATA_W(256)) dut (
        .clock(clock), .reset(reset), .ch_fire(ch_fire), .ch_opcode(ch_opcode), .ch_param(ch_param),
        .ch_source(ch_source), .ch_sink(ch_sink), .ch_address(ch_address), .ch_data(ch_data),
        .wen(wen), .channel(channel), .opcode(opcode), .param(param), .source(source), .sink(sink),
        .address(address), .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
        .stamp(stamp), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic idle();
        ch_fire    = '0;
        ch_opcode  = '0;
        ch_param   = '0;
        ch_source  = '0;
        ch_sink    = '0;
        ch_address = '0;
        ch_data    = '0;
    endtask

    task automatic set_ch(input int c, input logic [7:0] op, input logic [7:0] prm, input logic [7:0] src,
                          input logic [7:0] snk, input logic [63:0] addr, input logic [255:0] d);
        ch_fire[c]            = 1'b1;
        ch_opcode[8*c +: 8]   = op;
        ch_param[8*c +: 8]    = prm;
        ch_source[8*c +: 8]   = src;
        ch_sink[8*c +: 8]     = snk;
        ch_address[64*c +: 64] = addr;
        ch_data[256*c +: 256] = d;
    endtask

    task automatic fire_all(input logic [7:0] op);
        for (int c = 0; c < 5; c++)
            set_ch(c, op, 8'h00, 8'(c), 8'h00, 64'h0, 256'h0);
    endtask

    // Leaves the bench at a negedge in the first cycle after reset, where the stamp counter reads 0.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1;
        idle();
        repeat (2) @(negedge clock);
        checks++;
        if (wen !== 1'b0) begin failures++; $display("FAIL reset_wen: got %b expected 0", wen); end
        checks++;
        if ({channel, opcode, param, source, sink} !== 40'h0) begin
            failures++; $display("FAIL reset_fields: got %h expected 0", {channel, opcode, param, source, sink});
        end
        checks++;
        if ({address, data_0, data_1, data_2, data_3, stamp} !== 384'h0) begin
            failures++; $display("FAIL reset_wide: got addr %h stamp %h expected 0", address, stamp);
        end
        checks++;
        if ({drop_count, overflow} !== 33'h0) begin
            failures++; $display("FAIL reset_drop: got %h/%b expected 0/0", drop_count, overflow);
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        repeat (10) @(negedge clock);
        set_ch(0, 8'd4, 8'h00, 8'd3, 8'h00, 64'h8000_0040, 256'h01);
        @(negedge clock);
        idle();
        checks++;
        if (wen !== 1'b0) begin failures++; $display("FAIL single_early: got wen %b expected 0", wen); end
        @(negedge clock);
        checks++;
        if ({wen, channel, stamp} !== {1'b1, 8'd0, 64'd10}) begin
            failures++; $display("FAIL single_hdr: got %b/%0d/%0d expected 1/0/10", wen, channel, stamp);
        end
        checks++;
        if ({opcode, param, source, sink} !== {8'd4, 8'd0, 8'd3, 8'd0}) begin
            failures++; $display("FAIL single_fields: got %h expected 04000300", {opcode, param, source, sink});
        end
        checks++;
        if (address !== 64'h8000_0040) begin failures++; $display("FAIL single_addr: got %h expected 80000040", address); end
        checks++;
        if ({data_3, data_2, data_1, data_0} !== 256'h01) begin
            failures++; $display("FAIL single_data: got %h %h %h %h expected 0 0 0 1", data_3, data_2, data_1, data_0);
        end
        @(negedge clock);
        checks++;
        if ({wen, opcode, address} !== {1'b0, 8'd4, 64'h8000_0040}) begin
            failures++; $display("FAIL single_hold: got wen %b op %h addr %h expected 0 04 80000040", wen, opcode, address);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        repeat (20) @(negedge clock);
        for (int c = 0; c < 5; c++)
            set_ch(c, 8'(8'h10 + c), 8'(8'h20 + c), 8'(c), 8'(8'h30 + c), 64'(64'h1000 * (c + 1)),
                   {64'(64'hA0 + c), 64'h0, 64'h0, 64'(64'hB0 + c)});
        @(negedge clock);
        idle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            checks++;
            if ({wen, channel, stamp, opcode, param, sink} !== {1'b1, 8'(k), 64'd20, 8'(8'h10 + k), 8'(8'h20 + k), 8'(8'h30 + k)}) begin
                failures++; $display("FAIL simul_%0d: got wen %b ch %0d stamp %0d op %h prm %h snk %h expected ch %0d stamp 20",
                                     k, wen, channel, stamp, opcode, param, sink, k);
            end
            checks++;
            if ({address, data_3, data_0} !== {64'(64'h1000 * (k + 1)), 64'(64'hA0 + k), 64'(64'hB0 + k)}) begin
                failures++; $display("FAIL simul_payload_%0d: got addr %h d3 %h d0 %h", k, address, data_3, data_0);
            end
        end
        @(negedge clock);
        checks++;
        if (wen !== 1'b0) begin failures++; $display("FAIL simul_end: got wen %b expected 0", wen); end
    endtask

    // Cycle 27 after reset: C fires, then A and E together once rr has moved past C.
    task automatic test_round_robin();
        set_ch(2, 8'h2C, 8'h0, 8'h0, 8'h0, 64'h0, 256'h0);
        @(negedge clock);
        idle();
        set_ch(0, 8'h0A, 8'h0, 8'h0, 8'h0, 64'h0, 256'h0);
        set_ch(4, 8'h0E, 8'h0, 8'h0, 8'h0, 64'h0, 256'h0);
        @(negedge clock);
        idle();
        checks++;
        if ({wen, channel, opcode} !== {1'b1, 8'd2, 8'h2C}) begin
            failures++; $display("FAIL rr_c: got %b/%0d/%h expected 1/2/2c", wen, channel, opcode);
        end
        @(negedge clock);
        checks++;
        if ({wen, channel, opcode, stamp} !== {1'b1, 8'd4, 8'h0E, 64'd28}) begin
            failures++; $display("FAIL rr_e_first: got %b/%0d/%h/%0d expected 1/4/0e/28", wen, channel, opcode, stamp);
        end
        @(negedge clock);
        checks++;
        if ({wen, channel, opcode, stamp} !== {1'b1, 8'd0, 8'h0A, 64'd28}) begin
            failures++; $display("FAIL rr_a_second: got %b/%0d/%h/%0d expected 1/0/0a/28", wen, channel, opcode, stamp);
        end
    endtask

    task automatic test_overflow();
        int got;
        logic [7:0] e;
        got = 0;
        for (int n = 0; n < 14; n++) begin
            @(negedge clock);
            if (wen) begin
                checks++;
                if ({channel, opcode} !== {8'd1, 8'(got)}) begin
                    failures++; $display("FAIL stream_%0d: got ch %0d op %0d expected ch 1 op %0d", got, channel, opcode, got);
                end
                got++;
            end
            idle();
            if (n < 10) set_ch(1, 8'(n), 8'h0, 8'h0, 8'h0, 64'h0, 256'h0);
        end
        checks++;
        if ({got, drop_count, overflow} !== {32'd10, 32'd0, 1'b0}) begin
            failures++; $display("FAIL stream_total: got %0d recs %0d drops ovf %b expected 10 0 0", got, drop_count, overflow);
        end
        got = 0;
        for (int n = 0; n < 35; n++) begin
            @(negedge clock);
            if (wen) begin
                checks++;
                if (got > 26) begin
                    failures++; $display("FAIL burst_extra: got ch %0d op %0d expected no record", channel, opcode);
                end else begin
                    e = burst_seq[got];
                    if ({channel, opcode} !== {4'h0, e[7:4], 4'h0, e[3:0]}) begin
                        failures++; $display("FAIL burst_%0d: got ch %0d op %0d expected ch %0d op %0d",
                                             got, channel, opcode, e[7:4], e[3:0]);
                    end
                end
                got++;
            end
            idle();
            if (n < 8) fire_all(8'(n));
        end
        checks++;
        if ({got, drop_count, overflow} !== {32'd27, 32'd13, 1'b1}) begin
            failures++; $display("FAIL burst_total: got %0d recs %0d drops ovf %b expected 27 13 1", got, drop_count, overflow);
        end
    endtask

    task automatic test_saturation();
        @(negedge clock);
        force dut.drop_count = 32'hFFFF_FFFE;
        #1;
        release dut.drop_count;
        for (int n = 0; n < 6; n++) begin
            fire_all(8'(n));
            @(negedge clock);
        end
        idle();
        repeat (30) @(negedge clock);
        checks++;
        if ({drop_count, overflow} !== {32'hFFFF_FFFF, 1'b1}) begin
            failures++; $display("FAIL saturate: got %h/%b expected ffffffff/1", drop_count, overflow);
        end
    endtask

    task automatic test_reset_mid_drain();
        int bad;
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            fire_all(8'(n));
            @(negedge clock);
        end
        set_ch(0, 8'hEE, 8'h0, 8'h0, 8'h0, 64'h0, 256'h0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        idle();
        checks++;
        if ({wen, drop_count, overflow, stamp} !== {1'b0, 32'd0, 1'b0, 64'd0}) begin
            failures++; $display("FAIL mid_reset: got wen %b drops %0d ovf %b stamp %0d expected 0 0 0 0", wen, drop_count, overflow, stamp);
        end
        for (int n = 0; n < 5; n++) begin
            if (wen !== 1'b0) bad++;
            @(negedge clock);
        end
        checks++;
        if (bad !== 0) begin failures++; $display("FAIL mid_flush: got %0d wen cycles expected 0", bad); end
        set_ch(0, 8'h5A, 8'h0, 8'h0, 8'h0, 64'h0, 256'h0);
        @(negedge clock);
        idle();
        @(negedge clock);
        checks++;
        if ({wen, channel, opcode, stamp} !== {1'b1, 8'd0, 8'h5A, 64'd5}) begin
            failures++; $display("FAIL mid_restamp: got %b/%0d/%h/%0d expected 1/0/5a/5", wen, channel, opcode, stamp);
        end
    endtask

    task automatic test_stamp_wrap();
        @(negedge clock);
        force dut.stamp_cnt = 64'hFFFF_FFFF_FFFF_FFFE;
        set_ch(3, 8'd1, 8'h0, 8'h0, 8'h0, 64'h0, 256'h0);
        #1;
        release dut.stamp_cnt;
        @(negedge clock);
        set_ch(3, 8'd2, 8'h0, 8'h0, 8'h0, 64'h0, 256'h0);
        @(negedge clock);
        checks++;
        if ({wen, channel, opcode, stamp} !== {1'b1, 8'd3, 8'd1, 64'hFFFF_FFFF_FFFF_FFFE}) begin
            failures++; $display("FAIL wrap_fe: got %b/%0d/%0d/%h expected 1/3/1/fffffffffffffffe", wen, channel, opcode, stamp);
        end
        set_ch(3, 8'd3, 8'h0, 8'h0, 8'h0, 64'h0, 256'h0);
        @(negedge clock);
        idle();
        checks++;
        if ({wen, opcode, stamp} !== {1'b1, 8'd2, 64'hFFFF_FFFF_FFFF_FFFF}) begin
            failures++; $display("FAIL wrap_ff: got %b/%0d/%h expected 1/2/ffffffffffffffff", wen, opcode, stamp);
        end
        @(negedge clock);
        checks++;
        if ({wen, opcode, stamp, drop_count} !== {1'b1, 8'd3, 64'd0, 32'd0}) begin
            failures++; $display("FAIL wrap_zero: got %b/%0d/%h drops %0d expected 1/3/0/0", wen, opcode, stamp, drop_count);
        end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_single();
        test_simultaneous();
        test_round_robin();
        test_overflow();
        test_saturation();
        test_reset_mid_drain();
        test_stamp_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish within 100000 time units");
        $fatal(1);
    end
endmodule

// File: doc/tl_log_arbiter.md
# tl_log_arbiter

Front-end of the TileLink transaction logger. It sits directly upstream of the DPI log-writer stage. It captures beat-level fire events from the five TileLink channels (A–E) of one monitored link, and timestamps each one with a free-running cycle counter. Each channel's records are queued in its own small FIFO, and records are serialized round-robin into the single-record-per-cycle, non-stallable log-writer interface.

## Interface
Parameters:
- `FIFO_DEPTH`, default 4: entries per channel FIFO; power of two, ≥2.
- `DATA_W`, default 256: beat data width; fixed at 256 for the log writer, which takes four 64-bit data words.

Ports:
- `clock`, in, 1: sole clock.
- `reset`, in, 1: synchronous, active-high.
- `ch_fire`, in, 5: bit i = channel i beat handshake this cycle (A=0, B=1, C=2, D=3, E=4).
- `ch_opcode`, in, 5×8: per-channel opcode; channel i occupies bits [8i+7:8i].
- `ch_param`, in, 5×8: per-channel param.
- `ch_source`, in, 5×8: per-channel source ID; zero-extended by the caller.
- `ch_sink`, in, 5×8: per-channel sink ID.
- `ch_address`, in, 5×64: per-channel address; B carries its address, D and E drive 0.
- `ch_data`, in, 5×256: per-channel beat data; 0 for dataless channels.
- `wen`, out, 1: record valid to log writer.
- `channel`, out, 8: channel index 0–4 of the emitted record.
- `opcode`, `param`, `source`, `sink`, out, 8 each: fields of the emitted record.
- `address`, out, 64: address of the emitted record.
- `data_0`..`data_3`, out, 64 each: data_0 = beat bits [63:0], … , data_3 = bits [255:192].
- `stamp`, out, 64: cycle stamp captured at fire time.
- `drop_count`, out, 32: records lost to full FIFOs; saturating.
- `overflow`, out, 1: sticky; set on the first drop.

## Operation
- **Stamp counter.** 64-bit, 0 on reset, +1 every cycle, wraps modulo 2^64. A record fired in cycle t carries the counter value of cycle t.
- **Capture.** In any cycle, each channel with `ch_fire[i]=1` pushes {fields, stamp} into FIFO i. Up to 5 pushes per cycle.
- **Full FIFO.**
  - FIFO i full and no pop of FIFO i this cycle: the record is dropped, `drop_count` is incremented and `overflow` is set.
  - Multiple drops in one cycle add their count, saturating at 0xFFFF_FFFF.
  - Full FIFO with a simultaneous pop: the push is accepted and nothing is dropped.
- **Arbitration.**
  - Round-robin pointer `rr` (0–4), reset to 0.
  - Each cycle, grant the first non-empty FIFO scanning rr, rr+1, … mod 5.
  - Pop the granted FIFO; set rr = grant+1 mod 5.
  - No grant (all FIFOs empty): rr unchanged.
- **Output.** The granted head is loaded into the output register. `wen=1` for exactly one cycle per record. Output fields hold their last value while `wen=0`.
- **Ordering.** Per-channel order is preserved. Cross-channel order follows arbitration, not stamp; downstream sorts by stamp.
- **Backpressure.** None. The log writer accepts every cycle.

## Timing
- **Reset values.** `wen`=0; all record outputs 0; `drop_count`=0; `overflow`=0; stamp counter=0; rr=0; all FIFOs empty.
- **Latency.**
  - Fire in cycle t into an empty FIFO with no competing channel → `wen=1` in cycle t+2.
  - Push is visible at the FIFO head in t+1, and the output register is loaded at the end of t+1.
- **Throughput.** Sustained 1 record/cycle. Five simultaneous fires drain over 5 consecutive cycles, in rr order.
- **Reset mid-operation.**
  - Reset asserted in cycle r → FIFOs flushed, pending records discarded (not counted as drops), `wen=0` from cycle r+1.
  - Stamp restarts at 0 in the first cycle after reset deasserts.
  - `ch_fire` during reset is ignored.
- **Counter wrap.** Stamp wraps 0xFFFF…FFFF → 0 with no side effects.

## Test plan
- **Single record.** After reset, at cycle 10 fire A with opcode=4, source=3, address=0x8000_0040, data=0x…01 → `wen=1` at cycle 12 with channel=0, stamp=10, data_0=0x01, other outputs matching.
- **Simultaneous fire.** At cycle 20 fire all five channels, rr=0 → `wen` high at cycles 22–26 with channel 0,1,2,3,4, all stamp=20; rr ends at 0.
- **Round-robin fairness.** After granting C (rr=3), fire A and E in the same cycle → E emitted before A.
- **Overflow.** `FIFO_DEPTH`=4: hold B fire high for 10 cycles with all other channels idle → no drops (drain keeps pace). Then fire A, B, C, D, E every cycle for 8 cycles → `drop_count` and `overflow` match the model, per-channel order intact, `drop_count` saturates when forced near max.
- **Reset mid-drain.** Fill all FIFOs, then assert reset for 1 cycle → `wen=0` next cycle, `drop_count`=0, first post-reset fire carries a stamp counted from 0.
- **Stamp wrap.** Force the counter to 0xFFFF_FFFF_FFFF_FFFE and fire D on 3 consecutive cycles → stamps …FE, …FF, 0x0 in order.
